// File: rtl/hazard_scoreboard.sv
// D-stage hazard scoreboard: tracks in-flight GRF writers with self-decrementing
// Tnew counters and derives stall, rs/rt forwarding selects and mult/div busy.
module hazard_scoreboard #(
    parameter int REG_AW    = 5,
    parameter int STAGES    = 3,
    parameter int T_W       = 3,
    parameter int TUSE_NONE = 4,
    parameter int MD_LAT    = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          d_valid,
    input  logic [REG_AW-1:0]             d_rs,
    input  logic [REG_AW-1:0]             d_rt,
    input  logic [T_W-1:0]                d_rs_use,
    input  logic [T_W-1:0]                d_rt_use,
    input  logic                          d_reg_write,
    input  logic [REG_AW-1:0]             d_dst,
    input  logic [T_W-1:0]                d_tnew,
    input  logic                          d_md_start,
    input  logic                          d_md_use,
    input  logic                          flush,
    output logic                          stall,
    output logic [$clog2(STAGES+1)-1:0]   fwd_rs,
    output logic [$clog2(STAGES+1)-1:0]   fwd_rt,
    output logic                          md_busy
);

    localparam int FW = $clog2(STAGES + 1);
    localparam int MW = $clog2(MD_LAT + 1);

    logic              ent_v_reg    [1:STAGES];
    logic [REG_AW-1:0] ent_dst_reg  [1:STAGES];
    logic [T_W-1:0]    ent_tnew_reg [1:STAGES];
    logic              ent_v_next    [1:STAGES];
    logic [REG_AW-1:0] ent_dst_next  [1:STAGES];
    logic [T_W-1:0]    ent_tnew_next [1:STAGES];

    logic [MW-1:0]     md_cnt_reg;
    logic [MW-1:0]     md_cnt_next;
    logic              issue;

    logic [REG_AW-1:0] op_addr  [2];
    logic [T_W-1:0]    op_use   [2];
    logic              op_stall [2];
    logic [FW-1:0]     op_fwd   [2];

    assign issue = d_valid & ~stall & ~flush;

    // Entry 1 takes the issuing instruction (or a bubble); a write to $0 is never tracked.
    assign ent_v_next[1]    = issue & d_reg_write & (d_dst != '0);
    assign ent_dst_next[1]  = d_dst;
    assign ent_tnew_next[1] = d_tnew;

    genvar gi;
    generate
        for (gi = 2; gi <= STAGES; gi++) begin : g_shift
            assign ent_v_next[gi]    = ent_v_reg[gi-1];
            assign ent_dst_next[gi]  = ent_dst_reg[gi-1];
            assign ent_tnew_next[gi] = (ent_tnew_reg[gi-1] == '0) ? '0
                                     : ent_tnew_reg[gi-1] - T_W'(1);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= STAGES; k++) begin
                ent_v_reg[k]    <= 1'b0;
                ent_dst_reg[k]  <= '0;
                ent_tnew_reg[k] <= '0;
            end
            md_cnt_reg <= '0;
        end else begin
            for (int k = 1; k <= STAGES; k++) begin
                ent_v_reg[k]    <= ent_v_next[k];
                ent_dst_reg[k]  <= ent_dst_next[k];
                ent_tnew_reg[k] <= ent_tnew_next[k];
            end
            md_cnt_reg <= md_cnt_next;
        end
    end

    always_comb begin
        md_cnt_next = md_cnt_reg;
        if (issue && d_md_start) begin
            md_cnt_next = MW'(MD_LAT);
        end else if (md_cnt_reg != '0) begin
            md_cnt_next = md_cnt_reg - MW'(1);
        end
    end

    assign md_busy = (md_cnt_reg != '0);

    assign op_addr[0] = d_rs;
    assign op_addr[1] = d_rt;
    assign op_use[0]  = d_rs_use;
    assign op_use[1]  = d_rt_use;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_op
            logic          hit;
            logic [FW-1:0] idx;
            logic [T_W-1:0] m_tnew;

            // Scan oldest to youngest so the youngest matching writer wins.
            always_comb begin
                hit    = 1'b0;
                idx    = '0;
                m_tnew = '0;
                for (int k = STAGES; k >= 1; k--) begin
                    if (ent_v_reg[k] && (ent_dst_reg[k] == op_addr[gi]) && (op_addr[gi] != '0)) begin
                        hit    = 1'b1;
                        idx    = FW'(k);
                        m_tnew = ent_tnew_reg[k];
                    end
                end
            end

            assign op_stall[gi] = hit && (op_use[gi] != T_W'(TUSE_NONE)) && (m_tnew > op_use[gi]);
            assign op_fwd[gi]   = (hit && (m_tnew == '0)) ? idx : '0;
        end
    endgenerate

    assign stall  = d_valid & (op_stall[0] | op_stall[1] | (d_md_use & md_busy));
    assign fwd_rs = op_fwd[0];
    assign fwd_rt = op_fwd[1];

endmodule
